// File: rtl/moving_avg_fir_pkg.sv
// moving_avg_fir_pkg: filter-type codes, FSM encoding and default sizes shared by the filter.
package moving_avg_fir_pkg;
  localparam int DEF_SAMPLE_W = 12;
  localparam int DEF_DEPTH_LOG2 = 5;
  localparam int DEF_COEF_W = 16;
  typedef enum logic [2:0] {
    FT_AVG = 3'b000,
    FT_LOW = 3'b001,
    FT_HIGH = 3'b010,
    FT_BAND = 3'b011,
    FT_REJECT = 3'b100,
    FT_BYPASS = 3'b101
  } filterType;
  typedef enum logic [1:0] {IDLE, MAC, ROUND} stateType;
  function automatic logic isFir(input logic [2:0] t);
    return t inside {FT_LOW, FT_HIGH, FT_BAND, FT_REJECT};
  endfunction
endpackage

// File: rtl/fir_coef_rom.sv
// fir_coef_rom: registered Q1.(COEF_W-1) coefficient lookup by filter type and tap index.
module fir_coef_rom
  import moving_avg_fir_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int COEF_W = DEF_COEF_W
) (
  input  logic                     inClk,
  input  logic                     inResetN,
  input  logic [2:0]               inType,
  input  logic [DEPTH_LOG2-1:0]    inTap,
  output logic signed [COEF_W-1:0] outCoef
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int UNIT = 2 ** (COEF_W - 1 - DEPTH_LOG2);
  // Low pass is a linear taper; the rest are sign patterns nulling DC/Nyquist (band) or fs/4 (reject).
  function automatic int coefOf(input logic [2:0] t, input logic [DEPTH_LOG2-1:0] k);
    return t == FT_LOW ? (DEPTH - int'(k)) * 2 * UNIT / DEPTH
         : t == FT_HIGH ? (k[0] ? -2 * UNIT : 2 * UNIT)
         : t == FT_BAND ? (k[0] ? 0 : (k[1] ? -UNIT : UNIT))
         : t == FT_REJECT ? (k[0] ? 0 : UNIT) : 0;
  endfunction
  always_ff @(posedge inClk or negedge inResetN)
    if (!inResetN) outCoef <= '0;
    else outCoef <= COEF_W'(coefOf(inType, inTap));
endmodule

// File: rtl/moving_avg_fir.sv
// moving_avg_fir: circular-buffer moving average plus time-shared single-multiplier FIR.
module moving_avg_fir
  import moving_avg_fir_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int COEF_W = DEF_COEF_W
) (
  input  logic                       inClk,
  input  logic                       inResetN,
  input  logic signed [SAMPLE_W-1:0] inSample,
  input  logic                       inSampleReady,
  input  logic [2:0]                 inFilterType,
  output logic signed [SAMPLE_W-1:0] outSample,
  output logic                       outSampleReady,
  output logic                       outBusy,
  output logic                       outOverrun
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int SUM_W = SAMPLE_W + DEPTH_LOG2;
  localparam int ACC_W = SAMPLE_W + COEF_W + DEPTH_LOG2;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (COEF_W - 2));
  localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(2 ** (SAMPLE_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] MIN_S = ACC_W'(-(2 ** (SAMPLE_W - 1)));
  stateType state, nextState;
  logic signed [SAMPLE_W-1:0] sampleBuf [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr, newestPtr;
  logic signed [SUM_W-1:0] sum;
  logic signed [ACC_W-1:0] acc, rounded;
  logic [2:0] typeQ;
  logic [DEPTH_LOG2:0] tap;
  logic macValid, accept;
  logic signed [SAMPLE_W-1:0] tapSample, avgOut, firOut, result;
  logic signed [COEF_W-1:0] coef;
  logic signed [SAMPLE_W+COEF_W-1:0] product;

  fir_coef_rom #(.DEPTH_LOG2(DEPTH_LOG2), .COEF_W(COEF_W)) coefRom (
    .inClk(inClk),
    .inResetN(inResetN),
    .inType(typeQ),
    .inTap(tap[DEPTH_LOG2-1:0]),
    .outCoef(coef)
  );

  assign accept = inSampleReady && state == IDLE;
  assign newestPtr = wrPtr - 1'b1;
  assign outBusy = state != IDLE;
  assign product = tapSample * coef;
  assign avgOut = SAMPLE_W'(sum >>> DEPTH_LOG2);
  assign rounded = (acc + HALF) >>> (COEF_W - 1);
  assign firOut = rounded > MAX_S ? SAMPLE_W'(MAX_S) : rounded < MIN_S ? SAMPLE_W'(MIN_S) : SAMPLE_W'(rounded);
  assign result = typeQ == FT_AVG ? avgOut : isFir(typeQ) ? firOut : sampleBuf[newestPtr];

  // tap counts 0..DEPTH in MAC; its MSB marks the extra cycle that drains the ROM pipeline.
  always_comb begin
    nextState = state;
    nextState = state == IDLE ? (accept ? (isFir(inFilterType) ? MAC : ROUND) : IDLE)
              : state == MAC ? (tap[DEPTH_LOG2] ? ROUND : MAC) : IDLE;
  end

  always_ff @(posedge inClk or negedge inResetN)
    if (!inResetN) begin
      state <= IDLE;
      wrPtr <= '0;
      sum <= '0;
      acc <= '0;
      typeQ <= FT_AVG;
      tap <= '0;
      macValid <= 1'b0;
      tapSample <= '0;
      outSample <= '0;
      outSampleReady <= 1'b0;
      outOverrun <= 1'b0;
      for (int i = 0; i < DEPTH; i++) sampleBuf[i] <= '0;
    end else begin
      state <= nextState;
      outSampleReady <= state == ROUND;
      outOverrun <= inSampleReady && state != IDLE;
      macValid <= state == MAC && !tap[DEPTH_LOG2];
      tapSample <= sampleBuf[newestPtr - tap[DEPTH_LOG2-1:0]];
      tap <= state == MAC ? tap + 1'b1 : '0;
      if (accept) begin
        sampleBuf[wrPtr] <= inSample;
        wrPtr <= wrPtr + 1'b1;
        sum <= sum + SUM_W'(inSample) - SUM_W'(sampleBuf[wrPtr]);
        acc <= '0;
        typeQ <= inFilterType;
      end else if (macValid) acc <= acc + ACC_W'(product);
      if (state == ROUND) outSample <= result;
    end
endmodule

// File: tb/tb_moving_avg_fir.sv
// tb_moving_avg_fir: directed and random stimulus against a history-array reference model.
module tb_moving_avg_fir;
  logic inClk = 1'b0;
  logic inResetN = 1'b1;
  logic signed [11:0] inSample;
  logic inSampleReady;
  logic [2:0] inFilterType;
  logic signed [11:0] outSample;
  logic outSampleReady, outBusy, outOverrun;
  int vectors = 0;
  int miscompares = 0;
  int hist [32];
  int busyLeft = 0;
  int pendingExp = 0;
  int lastExp = 0;
  int lastDut = -9999;

  moving_avg_fir dut (
    .inClk(inClk),
    .inResetN(inResetN),
    .inSample(inSample),
    .inSampleReady(inSampleReady),
    .inFilterType(inFilterType),
    .outSample(outSample),
    .outSampleReady(outSampleReady),
    .outBusy(outBusy),
    .outOverrun(outOverrun)
  );

  always #5 inClk = ~inClk;

  task automatic check(input string tag, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int floorDiv(input int a, input int b);
    int q;
    q = a / b;
    if (a % b != 0 && a < 0) q--;
    return q;
  endfunction

  function automatic int coefModel(input int ft, input int k);
    int bp [4];
    bp = '{1024, 0, -1024, 0};
    if (ft == 1) return (32 - k) * 64;
    if (ft == 2) return (k % 2 == 0) ? 2048 : -2048;
    if (ft == 3) return bp[k % 4];
    return (k % 2 == 0) ? 1024 : 0;
  endfunction

  function automatic int modelOut(input int ft);
    int s;
    s = 0;
    if (ft == 0) begin
      for (int k = 0; k < 32; k++) s += hist[k];
      return floorDiv(s, 32);
    end
    if (ft > 4) return hist[0];
    for (int k = 0; k < 32; k++) s += coefModel(ft, k) * hist[k];
    s = floorDiv(s + 16384, 32768);
    return s > 2047 ? 2047 : (s < -2048 ? -2048 : s);
  endfunction

  task automatic step(input logic stb, input int smp, input int ft);
    logic busyBefore, pulse;
    inSampleReady = stb;
    inSample = 12'(smp);
    inFilterType = 3'(ft);
    @(posedge inClk);
    #1;
    busyBefore = busyLeft > 0;
    pulse = 1'b0;
    if (stb && !busyBefore) begin
      for (int k = 31; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = smp;
      pendingExp = modelOut(ft);
      busyLeft = (ft >= 1 && ft <= 4) ? 34 : 1;
    end else if (busyLeft > 0) begin
      busyLeft--;
      if (busyLeft == 0) begin
        pulse = 1'b1;
        lastExp = pendingExp;
      end
    end
    check("busy", int'(outBusy), int'(busyLeft > 0));
    check("ready", int'(outSampleReady), int'(pulse));
    check("overrun", int'(outOverrun), int'(stb && busyBefore));
    check("sample", int'(outSample), lastExp);
    if (pulse) lastDut = int'(outSample);
    inSampleReady = 1'b0;
  endtask

  task automatic applyReset();
    inResetN = 1'b0;
    inSampleReady = 1'b0;
    #1;
    busyLeft = 0;
    lastExp = 0;
    for (int k = 0; k < 32; k++) hist[k] = 0;
    check("rst_busy", int'(outBusy), 0);
    check("rst_ready", int'(outSampleReady), 0);
    check("rst_overrun", int'(outOverrun), 0);
    check("rst_sample", int'(outSample), 0);
    repeat (2) @(posedge inClk);
    #1 inResetN = 1'b1;
  endtask

  initial begin
    inSampleReady = 1'b0;
    inSample = '0;
    inFilterType = '0;
    #2 applyReset();
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 100, 0);
      repeat (3) step(1'b0, 0, 0);
      if (i == 0) check("avg_first", lastDut, 3);
    end
    check("avg_last", lastDut, 100);
    applyReset();
    for (int i = 0; i < 32; i++) begin
      step(1'b1, i == 0 ? 2047 : 0, 1);
      repeat (39) step(1'b0, 0, 1);
      if (i == 0) check("lp_tap0", lastDut, 128);
    end
    check("lp_tap31", lastDut, 4);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, (i % 2 == 1) ? -2048 : 2047, 2);
      repeat (35) step(1'b0, 0, 2);
    end
    check("hp_clamp", lastDut, -2048);
    step(1'b1, 500, 1);
    repeat (5) step(1'b0, 0, 1);
    step(1'b1, -300, 1);
    repeat (35) step(1'b0, 0, 1);
    step(1'b1, 321, 2);
    repeat (10) step(1'b0, 0, 2);
    applyReset();
    repeat (3) step(1'b0, 0, 5);
    step(1'b1, -700, 5);
    step(1'b0, 0, 5);
    check("bypass_out", lastDut, -700);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, int'($urandom_range(0, 4095)) - 2048, 0);
      repeat (3) step(1'b0, 0, 0);
    end
    step(1'b1, int'($urandom_range(0, 4095)) - 2048, 1);
    repeat (35) step(1'b0, 0, 1);
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) applyReset();
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 7)));
    end
    repeat (40) step(1'b0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
